// File: rtl/user_arith_engine.sv
// Shared iterative 32x32 multiply / restoring-divide engine fed by the Nios user register block.
// Define USER_ARITH_SIGNED_EN to enable two's-complement operation selected by ctrl_in[3].
module user_arith_engine #(
    parameter logic [15:0] ENGINE_ID = 16'hA178,
    parameter int          ITER      = 32        // must be 32; counter is 5 bits wide
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] ctrl_in,
    input  logic [31:0] opa_in,
    input  logic [31:0] opb_in,
    output logic [31:0] status_out,
    output logic [31:0] res_lo_out,
    output logic [31:0] res_hi_out,
    output logic [31:0] op_count_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [4:0] LAST   = 5'(ITER - 1);

    logic [0:0]  state_q, state_d;
    logic        go_q, go_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;          // multiplicand, or divisor for div
    logic [31:0] b_q, b_d;          // multiplier bits
    logic [63:0] acc_q, acc_d;      // product, or {remainder, dividend/quotient}
    logic        op_q, op_d;
    logic        sgn_q, sgn_d;
    logic        nq_q, nq_d;        // negate product / quotient at completion
    logic        nr_q, nr_d;        // negate remainder at completion
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic        last_q, last_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] ops_q, ops_d;

    logic        sgn_sel, unused_ctrl;
    logic        start, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;

`ifdef USER_ARITH_SIGNED_EN
    assign sgn_sel     = ctrl_in[3];
    assign unused_ctrl = ^{ctrl_in[31:4], ctrl_in[2]};
`else
    assign sgn_sel     = 1'b0;
    assign unused_ctrl = ^ctrl_in[31:2];
`endif

    assign start = ctrl_in[0] & ~go_q;
    assign neg_a = sgn_sel & opa_in[31];
    assign neg_b = sgn_sel & opb_in[31];
    assign mag_a = neg_a ? (~opa_in + 32'd1) : opa_in;
    assign mag_b = neg_b ? (~opb_in + 32'd1) : opb_in;

    // One iteration of the shared datapath.
    logic [32:0] add_sum, rem_sh, rem_sub;
    logic [63:0] acc_step, prod_s;
    logic [31:0] quo_s, rem_s, fin_lo, fin_hi;

    always_comb begin
        add_sum = {1'b0, acc_q[63:32]} + (b_q[cnt_q] ? {1'b0, a_q} : 33'd0);
        rem_sh  = {acc_q[63:32], acc_q[31]};
        rem_sub = rem_sh - {1'b0, a_q};
        if (op_q) begin
            if (rem_sh >= {1'b0, a_q})
                acc_step = {rem_sub[31:0], acc_q[30:0], 1'b1};
            else
                acc_step = {rem_sh[31:0], acc_q[30:0], 1'b0};
        end else begin
            acc_step = {add_sum, acc_q[31:1]};
        end
        prod_s = nq_q ? (~acc_step + 64'd1) : acc_step;
        quo_s  = nq_q ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
        rem_s  = nr_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
        fin_lo = op_q ? quo_s : prod_s[31:0];
        fin_hi = op_q ? rem_s : prod_s[63:32];
    end

    always_comb begin
        state_d = state_q;
        go_d    = ctrl_in[0];
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dz_d    = dz_q;
        last_d  = last_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ops_d   = ops_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d = 1'b0;
                    dz_d   = 1'b0;
                    op_d   = ctrl_in[1];
                    sgn_d  = sgn_sel;
                    if (ctrl_in[1] && (opb_in == 32'd0)) begin
                        // Divide by zero resolves on the accept edge, no RUN cycles.
                        lo_d   = 32'hFFFF_FFFF;
                        hi_d   = opa_in;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                        last_d = 1'b1;
                        ops_d  = ops_q + 32'd1;
                    end else begin
                        a_d     = ctrl_in[1] ? mag_b : mag_a;
                        b_d     = mag_b;
                        acc_d   = ctrl_in[1] ? {32'd0, mag_a} : 64'd0;
                        nq_d    = neg_a ^ neg_b;
                        nr_d    = neg_a;
                        cnt_d   = 5'd0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    lo_d    = fin_lo;
                    hi_d    = fin_hi;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    last_d  = op_q;
                    ops_d   = ops_q + 32'd1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset) begin
            state_q <= S_IDLE;
            go_q    <= 1'b0;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            op_q    <= 1'b0;
            sgn_q   <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            last_q  <= 1'b0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
            ops_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ops_q   <= ops_d;
        end
    end

    assign status_out   = {ENGINE_ID, 11'd0, sgn_q, last_q, dz_q, done_q, busy_q};
    assign res_lo_out   = lo_q;
    assign res_hi_out   = hi_q;
    assign op_count_out = ops_q;

endmodule
